clk_freq_monitor: RTL and testbench

Measures the frequency of a PLL output clock (sampled as a data signal) against a reference system clock and declares lock. It counts rising edges of the monitored clock over a fixed gate window of system-clock cycles and compares each window's count against a programmable range. It reports a lock / lost-lock status. It sits beside the DSP clock PLL and consumes its outputs (e.g. c0/c1 divided down) as a health check for the rest of the FPGA.

---
 rtl/clk_freq_monitor.sv | 133 +++++++++++++
 tb/tb_clk_freq_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_monitor.sv
// Checks a PLL-derived clock's frequency by counting its rising edges over a fixed window of clk cycles.
// Each window's count is range-checked, and a small FSM declares lock or reports a loss of lock.
module clk_freq_monitor #(
    parameter int GATE_CYCLES = 1024,
    parameter int CNT_WIDTH   = 16,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 mon_clk,
    input  logic [CNT_WIDTH-1:0] min_count,
    input  logic [CNT_WIDTH-1:0] max_count,
    output logic [CNT_WIDTH-1:0] count_out,
    output logic                 count_valid,
    output logic                 in_range,
    output logic                 locked,
    output logic                 lost_lock
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam logic [GW-1:0]        G_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [LW-1:0]        G_GOOD = LW'(LOCK_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] E_MAX  = '1;

    typedef enum logic [1:0] {ST_UNLOCKED, ST_ACQUIRE, ST_LOCKED} state_t;

    logic                 s1, s2, s3;
    logic                 mon_edge;
    logic [GW-1:0]        g;
    logic [CNT_WIDTH-1:0] e, e_next;
    state_t               state, state_next;
    logic [LW-1:0]        good, good_next;
    logic                 lost_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= mon_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign mon_edge = s2 & ~s3;
    assign e_next   = (mon_edge && (e != E_MAX)) ? e + 1'b1 : e;

    // An edge seen on the closing cycle is folded into the count for the window that is closing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            g           <= '0;
            e           <= '0;
            count_out   <= '0;
            count_valid <= 1'b0;
            in_range    <= 1'b0;
        end else if (!enable) begin
            g           <= '0;
            e           <= '0;
            count_valid <= 1'b0;
        end else if (g == G_LAST) begin
            g           <= '0;
            e           <= '0;
            count_out   <= e_next;
            count_valid <= 1'b1;
            in_range    <= (e_next >= min_count) && (e_next <= max_count);
        end else begin
            g           <= g + 1'b1;
            e           <= e_next;
            count_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_UNLOCKED;
            good      <= '0;
            lost_lock <= 1'b0;
        end else begin
            state     <= state_next;
            good      <= good_next;
            lost_lock <= lost_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_next = state;
        good_next  = good;
        lost_next  = 1'b0;
        if (!enable) begin
            state_next = ST_UNLOCKED;
            good_next  = '0;
        end else if (count_valid) begin
            case (state)
                ST_UNLOCKED: begin
                    if (in_range) begin
                        good_next  = LW'(1);
                        state_next = (LOCK_COUNT == 1) ? ST_LOCKED : ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (in_range) begin
                        good_next = good + 1'b1;
                        if (good == G_GOOD)
                            state_next = ST_LOCKED;
                    end else begin
                        good_next  = '0;
                        state_next = ST_UNLOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (!in_range) begin
                        good_next  = '0;
                        state_next = ST_UNLOCKED;
                        lost_next  = 1'b1;
                    end
                end
                default: begin
                    good_next  = '0;
                    state_next = ST_UNLOCKED;
                end
            endcase
        end
    end

    assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed bench for clk_freq_monitor: a table of window-count vectors plus sequences for
// lock, loss of lock, enable-low behaviour, saturation and asynchronous reset.
module tb_clk_freq_monitor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        mon_clk = 1'b0;
    logic [15:0] min_count, max_count, count_out;
    logic        count_valid, in_range, locked, lost_lock;
    logic [3:0]  sat_min, sat_max, sat_count_out;
    logic        sat_count_valid, sat_in_range, sat_locked, sat_lost_lock;

    int checks = 0;
    int errors = 0;
    int mon_period = 4;
    int ph = 0;
    int ll_pulses = 0;

    clk_freq_monitor #(.GATE_CYCLES(64), .CNT_WIDTH(16), .LOCK_COUNT(4)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mon_clk(mon_clk),
        .min_count(min_count), .max_count(max_count), .count_out(count_out),
        .count_valid(count_valid), .in_range(in_range), .locked(locked), .lost_lock(lost_lock)
    );

    clk_freq_monitor #(.GATE_CYCLES(128), .CNT_WIDTH(4), .LOCK_COUNT(4)) dut_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mon_clk(mon_clk),
        .min_count(sat_min), .max_count(sat_max), .count_out(sat_count_out),
        .count_valid(sat_count_valid), .in_range(sat_in_range), .locked(sat_locked),
        .lost_lock(sat_lost_lock)
    );

    always #5 clk = ~clk;

    // Monitored clock is generated in whole clk periods so window counts are exact.
    always @(negedge clk) begin
        if (mon_period == 0) begin
            mon_clk = 1'b0;
            ph = 0;
        end else begin
            if (ph >= mon_period) ph = 0;
            mon_clk = (ph >= mon_period / 2);
            ph = ph + 1;
        end
    end

    always @(negedge clk) if (reset_n && lost_lock) ll_pulses++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cv(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end while (!count_valid && cycles < budget);
        if (!count_valid) begin
            checks++;
            errors++;
            $display("FAIL cv_timeout: got no count_valid within %0d cycles", budget);
        end
    endtask

    task automatic restart(input int period, input int mn, input int mx);
        enable = 1'b0;
        mon_period = period;
        min_count = 16'(mn);
        max_count = 16'(mx);
        repeat (12) @(negedge clk);
        enable = 1'b1;
    endtask

    typedef struct {
        int          period;
        int          mn;
        int          mx;
        int unsigned exp_cnt;
        bit          exp_ir;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int cyc;
        int ll0;

        vecs[0] = '{4, 16, 16, 16, 1'b1};
        vecs[1] = '{4, 17, 20, 16, 1'b0};
        vecs[2] = '{4, 0, 15, 16, 1'b0};
        vecs[3] = '{8, 8, 8, 8, 1'b1};
        vecs[4] = '{8, 9, 7, 8, 1'b0};
        vecs[5] = '{16, 0, 65535, 4, 1'b1};
        vecs[6] = '{0, 0, 0, 0, 1'b1};
        vecs[7] = '{64, 1, 1, 1, 1'b1};

        reset_n = 1'b0;
        enable = 1'b0;
        min_count = 16'd15;
        max_count = 16'd17;
        sat_min = 4'd0;
        sat_max = 4'd15;
        repeat (3) @(negedge clk);
        check("rst_count_out", count_out, 0);
        check("rst_count_valid", count_valid, 0);
        check("rst_in_range", in_range, 0);
        check("rst_locked", locked, 0);
        check("rst_lost_lock", lost_lock, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            restart(vecs[i].period, vecs[i].mn, vecs[i].mx);
            wait_cv(200, cyc);
            check($sformatf("vec%0d_latency", i), cyc, 64);
            check($sformatf("vec%0d_count", i), count_out, vecs[i].exp_cnt);
            check($sformatf("vec%0d_in_range", i), in_range, vecs[i].exp_ir);
        end

        // Saturation: 32 edges per 128-cycle window into a 4-bit counter
        restart(4, 15, 17);
        cyc = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end while (!sat_count_valid && cyc < 300);
        check("sat_latency", cyc, 128);
        check("sat_count", sat_count_out, 15);
        check("sat_in_range", sat_in_range, 1);

        // Lock after four good windows
        restart(4, 15, 17);
        for (int k = 1; k <= 4; k++) begin
            wait_cv(200, cyc);
            check($sformatf("lock_cv%0d_count", k), count_out, 16);
            check($sformatf("lock_cv%0d_locked", k), locked, 0);
        end
        @(negedge clk);
        check("lock_rise", locked, 1);

        // Halve the monitored frequency: one lost_lock pulse only
        mon_period = 8;
        ll0 = ll_pulses;
        wait_cv(200, cyc);
        check("lost_in_range", in_range, 0);
        @(negedge clk);
        check("lost_pulse", lost_lock, 1);
        check("lost_locked", locked, 0);
        wait_cv(200, cyc);
        wait_cv(200, cyc);
        check("slow_count", count_out, 8);
        check("slow_in_range", in_range, 0);
        repeat (5) @(negedge clk);
        check("lost_pulse_total", ll_pulses - ll0, 1);

        // Three good, one bad, four good
        restart(4, 15, 17);
        ll0 = ll_pulses;
        for (int k = 1; k <= 8; k++) begin
            wait_cv(200, cyc);
            check($sformatf("seq_cv%0d_count", k), count_out, 16);
            check($sformatf("seq_cv%0d_in_range", k), in_range, (k != 4));
            if (k == 3) begin
                min_count = 16'd100;
                max_count = 16'd200;
            end
            if (k == 4) begin
                min_count = 16'd15;
                max_count = 16'd17;
            end
            @(negedge clk);
            check($sformatf("seq_cv%0d_locked", k), locked, (k == 8));
        end
        check("seq_no_lost", ll_pulses - ll0, 0);

        // Enable low mid-window while locked
        repeat (32) @(negedge clk);
        enable = 1'b0;
        ll0 = ll_pulses;
        @(negedge clk);
        check("dis_locked", locked, 0);
        check("dis_count_hold", count_out, 16);
        check("dis_count_valid", count_valid, 0);
        repeat (10) @(negedge clk);
        check("dis_no_lost", ll_pulses - ll0, 0);
        check("dis_count_hold2", count_out, 16);
        enable = 1'b1;
        wait_cv(200, cyc);
        check("reen_latency", cyc, 64);
        check("reen_count", count_out, 16);

        // Asynchronous reset mid-window while locked
        for (int k = 0; k < 3; k++) wait_cv(200, cyc);
        @(negedge clk);
        check("pre_rst_locked", locked, 1);
        repeat (20) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_count_out", count_out, 0);
        check("arst_count_valid", count_valid, 0);
        check("arst_in_range", in_range, 0);
        check("arst_locked", locked, 0);
        check("arst_lost_lock", lost_lock, 0);
        check("arst_sat_count", sat_count_out, 0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_cv(200, cyc);
        check("post_rst_latency", cyc, 64);
        check("post_rst_count", count_out, 16);
        check("post_rst_in_range", in_range, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
